ecc_scrubber: RTL and testbench
===============================

# ecc_scrubber

Background ECC scrubber for one port of the hamming-protected dual-port memory. It walks the address space at a programmable interval, issues a read, and inspects the decoder's single/double-bit error flags. On a correctable error it writes the corrected word back to the same address. On an uncorrectable error it logs the address instead. It sits beside the port's host traffic as a low-priority requester behind an external grant.

## Interface
- DATA_WIDTH, 8, width of the user data word (pre-encoding)
- ADDR_WIDTH, 4, address width; the scrub range is 0 .. 2**ADDR_WIDTH-1
- RD_LATENCY, 2, cycles from accepted read to valid i_dout and flags (≥1)
- WR_LATENCY, 1, cycles from accepted write to write completion (≥1)
- INTERVAL, 16, idle cycles between consecutive scrub reads (≥1)
- CNT_WIDTH, 16, width of the error counters
- clka  input  1  clock; all logic on the rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_scrub_en  input  1  level; enables scrubbing
- i_grant  input  1  arbiter accepts the current o_en request this cycle
- o_en  output  1  port request
- o_we  output  1  1 = write, 0 = read
- o_addr  output  ADDR_WIDTH  request address
- o_din  output  DATA_WIDTH  write-back data
- i_dout  input  DATA_WIDTH  corrected read data from the decoder
- i_sbit_err  input  1  single-bit (corrected) error flag, valid with i_dout
- i_dbit_err  input  1  double-bit (uncorrectable) error flag, valid with i_dout
- o_busy  output  1  FSM is not in IDLE
- o_sbit_cnt  output  CNT_WIDTH  saturating count of corrected errors
- o_dbit_cnt  output  CNT_WIDTH  saturating count of uncorrectable errors
- o_dbit_addr  output  ADDR_WIDTH  address of the most recent uncorrectable error
- o_pass_done  output  1  one-cycle pulse when an address wrap completes a pass

## Operation
- FSM states: IDLE, WAIT, RD_REQ, RD_WAIT, CHECK, WB_REQ, WB_WAIT, NEXT.
- IDLE → WAIT when i_scrub_en=1. The interval counter loads INTERVAL-1.
- WAIT: the counter decrements each cycle. At 0, go to RD_REQ.
- RD_REQ: drive o_en=1, o_we=0, o_addr=scrub address. Hold these values until i_grant=1, then go to RD_WAIT. The latency counter loads RD_LATENCY-1.
- RD_WAIT: the counter decrements. At 0, go to CHECK. i_dout and the flags are sampled on this transition edge.
- CHECK, evaluated on the sampled values:
  - i_dbit_err=1: o_dbit_cnt increments and o_dbit_addr takes the current address. No write-back. Go to NEXT.
  - i_sbit_err=1 only: o_sbit_cnt increments. Latch i_dout into o_din. Go to WB_REQ.
  - No flag: go to NEXT.
  - If both flags are set, the double-bit error takes priority.
- WB_REQ: drive o_en=1, o_we=1, same o_addr, o_din. Hold until i_grant=1. Then go to WB_WAIT; the counter loads WR_LATENCY-1.
- WB_WAIT: at 0, go to NEXT.
- NEXT: the address increments. When the address is 2**ADDR_WIDTH-1, it wraps to 0 and o_pass_done pulses. Then:
  - i_scrub_en=1: go to WAIT (reload INTERVAL-1).
  - i_scrub_en=0: go to IDLE.
- Deassertion of i_scrub_en is honoured only in WAIT (→ IDLE immediately) and in NEXT. An outstanding read or write-back always completes.
- Counters saturate at 2**CNT_WIDTH-1 and never wrap.
- The scrub address persists across IDLE. A new enable resumes where the previous pass stopped.
- o_en=0 in every state except RD_REQ and WB_REQ.

## Timing
- Reset values: state IDLE, address 0, o_en=0, o_we=0, o_addr=0, o_din=0, o_busy=0, o_sbit_cnt=0, o_dbit_cnt=0, o_dbit_addr=0, o_pass_done=0.
- Reset mid-operation: abandon any outstanding request immediately. o_en drops asynchronously.
- All outputs are registered. o_busy reflects the current state.
- No-error scrub period with i_grant tied to 1: INTERVAL + 1 (RD_REQ) + RD_LATENCY + 1 (CHECK) + 1 (NEXT) cycles.
  - Default parameters: 21 cycles per address, 336 cycles per pass.
- A corrected error adds 1 + WR_LATENCY cycles.
- Each cycle i_grant=0 in a REQ state adds one cycle. o_addr, o_we and o_din stay stable throughout.

## Test plan
- Clean memory, i_grant=1, default parameters, i_scrub_en held high:
  - 16 reads at addresses 0..15, 21 cycles apart, and no writes.
  - o_pass_done pulses once, 336 cycles after the first WAIT cycle.
  - Both counters stay 0.
- Inject a single-bit error at address 5 (stored data 0xA5):
  - The read at 5 returns i_sbit_err=1 and i_dout=0xA5.
  - o_sbit_cnt becomes 1.
  - A write to address 5 with o_din=0xA5 follows 1 cycle after CHECK.
  - The next pass sees no error at 5.
- Inject a double-bit error at address 9:
  - o_dbit_cnt becomes 1 and o_dbit_addr becomes 9.
  - No write is issued.
  - The scan continues at 10.
- Hold i_grant=0 for 7 cycles during RD_REQ at address 3:
  - o_en=1, o_we=0 and o_addr=3 stay stable for all 8 cycles.
  - The read is accepted on the first i_grant=1 cycle.
- Drop i_scrub_en during RD_WAIT at address 12:
  - The read completes through NEXT, the address becomes 13, and the FSM enters IDLE with o_busy=0.
  - Re-enabling starts the next read at address 13.
- Assert i_rst_n=0 during WB_REQ:
  - o_en goes to 0 immediately.
  - All counters and o_addr read 0 after reset.
  - The first read after re-enable targets address 0.

Source files
------------

// File: rtl/ecc_scrubber.sv
// Background ECC scrubber: walks the address space, reads each word, writes back
// corrected single-bit errors and logs uncorrectable ones. Low-priority requester behind i_grant.
module ecc_scrubber #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1,
  parameter int INTERVAL   = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clka,
  input  logic                  i_rst_n,
  input  logic                  i_scrub_en,
  input  logic                  i_grant,
  output logic                  o_en,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_din,
  input  logic [DATA_WIDTH-1:0] i_dout,
  input  logic                  i_sbit_err,
  input  logic                  i_dbit_err,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_sbit_cnt,
  output logic [CNT_WIDTH-1:0]  o_dbit_cnt,
  output logic [ADDR_WIDTH-1:0] o_dbit_addr,
  output logic                  o_pass_done,
  output logic [2:0]            o_dbg_state
);

  // Request handshake: o_en/o_we/o_addr/o_din are held stable while o_en=1;
  // a request is consumed on the rising edge where o_en=1 and i_grant=1.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_CHECK   = 3'd4,
    S_WB_REQ  = 3'd5,
    S_WB_WAIT = 3'd6,
    S_NEXT    = 3'd7
  } state_t;

  localparam int TMAX_A = (INTERVAL > RD_LATENCY) ? INTERVAL : RD_LATENCY;
  localparam int TMAX   = (TMAX_A > WR_LATENCY) ? TMAX_A : WR_LATENCY;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] INT_LOAD = TW'(INTERVAL - 1);
  localparam logic [TW-1:0] RD_LOAD  = TW'(RD_LATENCY - 1);
  localparam logic [TW-1:0] WR_LOAD  = TW'(WR_LATENCY - 1);

  state_t                state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  sbit_q, sbit_d;
  logic                  dbit_q, dbit_d;
  logic                  en_q, en_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  pass_done_q, pass_done_d;
  logic [CNT_WIDTH-1:0]  sbit_cnt_q, sbit_cnt_d;
  logic [CNT_WIDTH-1:0]  dbit_cnt_q, dbit_cnt_d;
  logic [ADDR_WIDTH-1:0] dbit_addr_q, dbit_addr_d;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    addr_d      = addr_q;
    din_d       = din_q;
    rdata_d     = rdata_q;
    sbit_d      = sbit_q;
    dbit_d      = dbit_q;
    pass_done_d = 1'b0;
    sbit_cnt_d  = sbit_cnt_q;
    dbit_cnt_d  = dbit_cnt_q;
    dbit_addr_d = dbit_addr_q;

    case (state_q)
      S_IDLE: begin
        if (i_scrub_en) begin
          state_d = S_WAIT;
          tmr_d   = INT_LOAD;
        end
      end
      S_WAIT: begin
        if (!i_scrub_en)        state_d = S_IDLE;
        else if (tmr_q == '0)   state_d = S_RD_REQ;
        else                    tmr_d   = tmr_q - TW'(1);
      end
      S_RD_REQ: begin
        if (i_grant) begin
          state_d = S_RD_WAIT;
          tmr_d   = RD_LOAD;
        end
      end
      S_RD_WAIT: begin
        if (tmr_q == '0) begin
          state_d = S_CHECK;
          rdata_d = i_dout;
          sbit_d  = i_sbit_err;
          dbit_d  = i_dbit_err;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_CHECK: begin
        // Uncorrectable wins when both flags are reported.
        if (dbit_q) begin
          if (dbit_cnt_q != '1) dbit_cnt_d = dbit_cnt_q + CNT_WIDTH'(1);
          dbit_addr_d = addr_q;
          state_d     = S_NEXT;
        end else if (sbit_q) begin
          if (sbit_cnt_q != '1) sbit_cnt_d = sbit_cnt_q + CNT_WIDTH'(1);
          din_d   = rdata_q;
          state_d = S_WB_REQ;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WB_REQ: begin
        if (i_grant) begin
          state_d = S_WB_WAIT;
          tmr_d   = WR_LOAD;
        end
      end
      S_WB_WAIT: begin
        if (tmr_q == '0) state_d = S_NEXT;
        else             tmr_d   = tmr_q - TW'(1);
      end
      S_NEXT: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (addr_q == '1) pass_done_d = 1'b1;
        if (i_scrub_en) begin
          state_d = S_WAIT;
          tmr_d   = INT_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    en_d   = (state_d == S_RD_REQ) || (state_d == S_WB_REQ);
    we_d   = (state_d == S_WB_REQ);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clka or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      rdata_q     <= '0;
      sbit_q      <= 1'b0;
      dbit_q      <= 1'b0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      pass_done_q <= 1'b0;
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      dbit_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rdata_q     <= rdata_d;
      sbit_q      <= sbit_d;
      dbit_q      <= dbit_d;
      en_q        <= en_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      pass_done_q <= pass_done_d;
      sbit_cnt_q  <= sbit_cnt_d;
      dbit_cnt_q  <= dbit_cnt_d;
      dbit_addr_q <= dbit_addr_d;
    end
  end

  assign o_en        = en_q;
  assign o_we        = we_q;
  assign o_addr      = addr_q;
  assign o_din       = din_q;
  assign o_busy      = busy_q;
  assign o_sbit_cnt  = sbit_cnt_q;
  assign o_dbit_cnt  = dbit_cnt_q;
  assign o_dbit_addr = dbit_addr_q;
  assign o_pass_done = pass_done_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_ecc_scrubber.sv
// Bench for ecc_scrubber: memory model with error injection, request scoreboard,
// pass timing and counter checks, grant stall, enable drop and mid-write reset.
module tb_ecc_scrubber;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 16;
  localparam int ET = 2 + AW + DW;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;

  logic          clka = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_scrub_en = 1'b0;
  logic          i_grant = 1'b1;
  logic          o_en, o_we;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_din;
  logic [DW-1:0] i_dout;
  logic          i_sbit_err, i_dbit_err;
  logic          o_busy;
  logic [CW-1:0] o_sbit_cnt, o_dbit_cnt;
  logic [AW-1:0] o_dbit_addr;
  logic          o_pass_done;
  logic [2:0]    o_dbg_state;

  ecc_scrubber dut (
    .clka(clka), .i_rst_n(i_rst_n), .i_scrub_en(i_scrub_en), .i_grant(i_grant),
    .o_en(o_en), .o_we(o_we), .o_addr(o_addr), .o_din(o_din),
    .i_dout(i_dout), .i_sbit_err(i_sbit_err), .i_dbit_err(i_dbit_err),
    .o_busy(o_busy), .o_sbit_cnt(o_sbit_cnt), .o_dbit_cnt(o_dbit_cnt),
    .o_dbit_addr(o_dbit_addr), .o_pass_done(o_pass_done), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  // ---------------- memory model (read latency 2) ----------------
  logic [DW-1:0] mem [16];
  logic          sbit_inj [16];
  logic          dbit_inj [16];
  logic          wr_seen [16];
  logic          rd_v0 = 1'b0, rd_v1 = 1'b0;
  logic [AW-1:0] rd_a0 = '0, rd_a1 = '0;

  always @(posedge clka) begin
    rd_v0 <= o_en && i_grant && !o_we;
    rd_a0 <= o_addr;
    rd_v1 <= rd_v0;
    rd_a1 <= rd_a0;
    if (!i_rst_n) begin
      for (int i = 0; i < 16; i++) wr_seen[i] <= 1'b0;
    end else if (o_en && i_grant && o_we) begin
      wr_seen[o_addr] <= 1'b1;
    end
  end

  assign i_dout     = rd_v1 ? mem[rd_a1] : '0;
  assign i_sbit_err = rd_v1 && sbit_inj[rd_a1] && !wr_seen[rd_a1];
  assign i_dbit_err = rd_v1 && dbit_inj[rd_a1];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry: {valid, we, addr, din}; din is zero for reads.
  logic [ET-1:0] exp_q [$];
  int            acc_cyc_q [$];
  int            acc_cnt  = 0;
  int            pass_cnt = 0;
  int            pass_cyc = 0;

  task automatic push_rd(input int a);
    exp_q.push_back({1'b1, 1'b0, AW'(a), {DW{1'b0}}});
  endtask

  task automatic push_wr(input int a, input logic [DW-1:0] d);
    exp_q.push_back({1'b1, 1'b1, AW'(a), d});
  endtask

  always @(negedge clka) begin
    if (i_rst_n && o_en && i_grant) begin
      logic [ET-1:0] exp_e;
      logic [ET-1:0] obs_e;
      exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      obs_e = {1'b1, o_we, o_addr, o_we ? o_din : {DW{1'b0}}};
      check_eq("req", 32'(obs_e), 32'(exp_e));
      acc_cyc_q.push_back(cyc);
      acc_cnt++;
    end
    if (i_rst_n && o_pass_done) begin
      pass_cnt++;
      pass_cyc = cyc;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic wait_pass(input int target, input string tag);
    int b;
    b = 0;
    while (pass_cnt < target && b < 500) begin tick(); b++; end
    check_eq(tag, pass_cnt, target);
  endtask

  task automatic wait_acc(input int target, input string tag);
    int b;
    b = 0;
    while (acc_cnt < target && b < 500) begin tick(); b++; end
    check_eq(tag, acc_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t_en;
    int b;
    for (int i = 0; i < 16; i++) begin
      mem[i]      = DW'($urandom_range(0, 255));
      sbit_inj[i] = 1'b0;
      dbit_inj[i] = 1'b0;
    end

    // Reset values
    repeat (3) @(posedge clka);
    @(negedge clka);
    check_eq("rst_en_we", {o_en, o_we}, 0);
    check_eq("rst_addr", o_addr, 0);
    check_eq("rst_din", o_din, 0);
    check_eq("rst_busy_pd", {o_busy, o_pass_done}, 0);
    check_eq("rst_cnts", {o_sbit_cnt, o_dbit_cnt}, 0);
    check_eq("rst_dbit_addr", o_dbit_addr, 0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Pass 1: clean memory, grant always
    for (int a = 0; a < 16; a++) push_rd(a);
    i_scrub_en = 1'b1;
    t_en = cyc;
    wait_pass(1, "pass1_done");
    check_eq("pass1_nreq", acc_cyc_q.size(), 16);
    for (int k = 0; k < 16 && k < acc_cyc_q.size(); k++)
      check_eq($sformatf("pass1_rd%0d_cyc", k), acc_cyc_q[k], t_en + 17 + 21 * k);
    check_eq("pass1_done_cyc", pass_cyc, t_en + 1 + 336);
    check_eq("pass1_cnts", {o_sbit_cnt, o_dbit_cnt}, 0);
    check_eq("pass1_q_empty", exp_q.size(), 0);

    // Pass 2: sbit at 5, dbit at 9, grant stall at 3
    acc_cyc_q.delete();
    mem[5]      = 8'hA5;
    sbit_inj[5] = 1'b1;
    dbit_inj[9] = 1'b1;
    for (int a = 0; a < 16; a++) begin
      push_rd(a);
      if (a == 5) push_wr(5, 8'hA5);
    end
    b = 0;
    while (!(o_en && !o_we && o_addr == 4'd3) && b < 200) begin tick(); b++; end
    check_eq("stall_reach", {o_en, o_we, o_addr}, {1'b1, 1'b0, 4'd3});
    i_grant = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clka);
      check_eq($sformatf("stall_hold%0d", k), {o_en, o_we, o_addr}, {1'b1, 1'b0, 4'd3});
      tick();
    end
    check_eq("stall_hold7", {o_en, o_we, o_addr}, {1'b1, 1'b0, 4'd3});
    i_grant = 1'b1;
    tick();
    check_eq("stall_accepted", o_en, 0);
    wait_pass(2, "pass2_done");
    check_eq("pass2_sbit_cnt", o_sbit_cnt, 1);
    check_eq("pass2_dbit_cnt", o_dbit_cnt, 1);
    check_eq("pass2_dbit_addr", o_dbit_addr, 9);
    check_eq("pass2_nreq", acc_cyc_q.size(), 17);
    if (acc_cyc_q.size() == 17) begin
      check_eq("stall_gap", acc_cyc_q[3] - acc_cyc_q[2], 21 + 7);
      check_eq("wb_gap", acc_cyc_q[6] - acc_cyc_q[5], 4);
      check_eq("dbit_gap", acc_cyc_q[11] - acc_cyc_q[10], 21);
    end
    check_eq("pass2_q_empty", exp_q.size(), 0);
    sbit_inj[5] = 1'b0;
    dbit_inj[9] = 1'b0;

    // Pass 3: drop enable during the read at 12
    for (int a = 0; a <= 12; a++) push_rd(a);
    wait_acc(acc_cnt + 13, "pass3_reach12");
    tick();
    check_eq("drop_state", {o_dbg_state, o_addr}, {ST_RD_WAIT, 4'd12});
    i_scrub_en = 1'b0;
    b = 0;
    while (o_busy && b < 20) begin tick(); b++; end
    check_eq("drop_idle_addr", {o_busy, o_addr}, {1'b0, 4'd13});
    check_eq("pass3_sbit_cnt", o_sbit_cnt, 1);
    check_eq("pass3_dbit_cnt", o_dbit_cnt, 1);
    repeat (5) tick();
    check_eq("idle_quiet", {o_busy, o_en}, 0);
    push_rd(13);
    i_scrub_en = 1'b1;
    t_en = cyc;
    wait_acc(acc_cnt + 1, "resume_rd13");
    check_eq("resume_cyc", acc_cyc_q[acc_cyc_q.size() - 1], t_en + 17);

    // Reset while a write-back is pending
    mem[14]      = 8'h3C;
    sbit_inj[14] = 1'b1;
    push_rd(14);
    b = 0;
    while (!(o_en && o_we) && b < 60) begin tick(); b++; end
    i_grant = 1'b0;
    check_eq("wb_req_seen", {o_en, o_we, o_addr, o_din}, {1'b1, 1'b1, 4'd14, 8'h3C});
    check_eq("wb_sbit_cnt", o_sbit_cnt, 2);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("rst_async_en", o_en, 0);
    check_eq("rst2_addr_din", {o_addr, o_din}, 0);
    check_eq("rst2_cnts", {o_sbit_cnt, o_dbit_cnt, o_dbit_addr}, 0);
    check_eq("rst2_busy", o_busy, 0);
    check_eq("rst2_q_empty", exp_q.size(), 0);
    i_scrub_en   = 1'b0;
    sbit_inj[14] = 1'b0;
    repeat (3) tick();
    i_rst_n = 1'b1;
    i_grant = 1'b1;
    tick();
    push_rd(0);
    i_scrub_en = 1'b1;
    t_en = cyc;
    wait_acc(acc_cnt + 1, "post_rst_rd0");
    check_eq("post_rst_cyc", acc_cyc_q[acc_cyc_q.size() - 1], t_en + 17);
    i_scrub_en = 1'b0;
    repeat (10) tick();
    check_eq("final_idle", {o_busy, o_en, o_addr}, {1'b0, 1'b0, 4'd1});
    check_eq("final_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
